// File: rtl/jogo_pkg.sv
// Shared state encodings and parameter defaults for the sequence game controller.
// The db_estado debug values are fixed by the enum encodings below.
package jogo_pkg;

  localparam int JOGO_DATA_W         = 4;
  localparam int JOGO_DEPTH          = 16;
  localparam int JOGO_TIMEOUT_CYCLES = 5000;

  typedef enum logic [3:0] {
    ST_INICIAL     = 4'h0,
    ST_PREPARACAO  = 4'h1,
    ST_LE_MEM      = 4'h2,
    ST_ESPERA      = 4'h3,
    ST_REGISTRA    = 4'h4,
    ST_COMPARACAO  = 4'h5,
    ST_PROXIMO     = 4'h6,
    ST_FIM_ACERTO  = 4'hA,
    ST_FIM_TIMEOUT = 4'hD,
    ST_FIM_ERRO    = 4'hE
  } estado_e;

  function automatic logic is_fim(input estado_e e);
    return (e == ST_FIM_ACERTO) || (e == ST_FIM_ERRO) || (e == ST_FIM_TIMEOUT);
  endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector with synchronous active-high reset; the pulse is
// combinational so it lines up with the cycle the input first goes high.
module edge_detector (
  input  logic clock,
  input  logic reset,
  input  logic sinal_i,
  output logic borda_o
);

  logic prev_q;

  always_ff @(posedge clock) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= sinal_i;
  end

  assign borda_o = sinal_i & ~prev_q;

endmodule

// File: rtl/circuito_jogo_sequencia.sv
// Sequence game: walks DEPTH memory entries, compares one player move per entry.
// Optional inactivity timeout in espera is enabled by defining JOGO_TIMEOUT_EN.
module circuito_jogo_sequencia
  import jogo_pkg::*;
#(
  parameter int DATA_W         = JOGO_DATA_W,
  parameter int DEPTH          = JOGO_DEPTH,
  parameter int ADDR_W         = $clog2(DEPTH),
  parameter int TIMEOUT_CYCLES = JOGO_TIMEOUT_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic [DATA_W-1:0] chaves,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pronto,
  output logic              acertou,
  output logic              errou,
  output logic              timeout,
  output logic [3:0]        db_estado,
  output logic [ADDR_W-1:0] db_contagem,
  output logic [DATA_W-1:0] db_jogada,
  output logic              db_igual
);

  estado_e           estado_q, estado_d;
  logic [ADDR_W-1:0] cont_q, cont_d;
  logic [DATA_W-1:0] jogada_q, jogada_d;
  logic              evento;
  logic              igual;
  logic              idle_tc;

  edge_detector u_edge (
    .clock   (clock),
    .reset   (reset),
    .sinal_i (|chaves),
    .borda_o (evento)
  );

  // A zero move is never a real move, so it must not match a zero memory word.
  assign igual = (jogada_q == mem_data) && (|jogada_q);

`ifdef JOGO_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d = '0;
    if (estado_q == ST_ESPERA) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end

  assign idle_tc = (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign timeout = (estado_q == ST_FIM_TIMEOUT);
`else
  assign idle_tc = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    jogada_d = jogada_q;
    case (estado_q)
      ST_INICIAL:    if (iniciar) estado_d = ST_PREPARACAO;
      ST_PREPARACAO: begin
        cont_d   = '0;
        jogada_d = '0;
        estado_d = ST_LE_MEM;
      end
      ST_LE_MEM:     estado_d = ST_ESPERA;
      ST_ESPERA: begin
        if (evento)       estado_d = ST_REGISTRA;
        else if (idle_tc) estado_d = ST_FIM_TIMEOUT;
      end
      ST_REGISTRA: begin
        jogada_d = chaves;
        estado_d = ST_COMPARACAO;
      end
      ST_COMPARACAO: begin
        if (!igual)                              estado_d = ST_FIM_ERRO;
        else if (cont_q == ADDR_W'(DEPTH - 1))   estado_d = ST_FIM_ACERTO;
        else                                     estado_d = ST_PROXIMO;
      end
      ST_PROXIMO: begin
        cont_d   = cont_q + 1'b1;
        estado_d = ST_LE_MEM;
      end
      ST_FIM_ACERTO, ST_FIM_ERRO, ST_FIM_TIMEOUT:
        if (iniciar) estado_d = ST_PREPARACAO;
      default:       estado_d = ST_INICIAL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
      cont_q   <= '0;
      jogada_q <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
      jogada_q <= jogada_d;
    end
  end

  assign mem_addr    = cont_q;
  assign db_contagem = cont_q;
  assign db_jogada   = jogada_q;
  assign db_estado   = estado_q;
  assign db_igual    = igual;
  assign pronto      = is_fim(estado_q);
  assign acertou     = (estado_q == ST_FIM_ACERTO);
  assign errou       = (estado_q == ST_FIM_ERRO);

endmodule

// File: tb/tb_circuito_jogo_sequencia.sv
// Directed bench for circuito_jogo_sequencia with DEPTH=4, memory 1,2,4,8.
module tb_circuito_jogo_sequencia;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] chaves;
  logic [3:0] mem_data = 4'h0;
  logic [1:0] mem_addr;
  logic       pronto, acertou, errou, timeout, db_igual;
  logic [3:0] db_estado, db_jogada;
  logic [1:0] db_contagem;
  logic [3:0] mem [4];

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  always @(posedge clock) mem_data <= mem[mem_addr];

  circuito_jogo_sequencia #(
    .DATA_W(4), .DEPTH(4), .TIMEOUT_CYCLES(10)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
    .mem_data(mem_data), .mem_addr(mem_addr), .pronto(pronto),
    .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado), .db_contagem(db_contagem),
    .db_jogada(db_jogada), .db_igual(db_igual)
  );

  task automatic wait_espera();
    int n = 0;
    while (db_estado !== 4'h3 && n < 30) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (db_estado !== 4'h3) begin
      fails++;
      $display("FAIL wait_espera: estado=%h required 3 within 30 cycles", db_estado);
    end
  endtask

  task automatic press(input logic [3:0] v, input logic exp_igual);
    wait_espera();
    chaves = v;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h4) begin
      fails++; $display("FAIL press_registra: estado=%h required 4", db_estado);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h5 || db_jogada !== v || db_igual !== exp_igual) begin
      fails++;
      $display("FAIL press_compare: estado=%h jogada=%h igual=%b required 5 %h %b",
               db_estado, db_jogada, db_igual, v, exp_igual);
    end
    chaves = 4'h0;
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    checks++;
    if (db_estado !== 4'h1) begin
      fails++; $display("FAIL start_prep: estado=%h required 1", db_estado);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; chaves = 4'h0;
    repeat (2) @(negedge clock);
    checks++;
    if ({pronto, acertou, errou, timeout, db_igual} !== 5'b0 || db_estado !== 4'h0 ||
        mem_addr !== 2'd0 || db_contagem !== 2'd0 || db_jogada !== 4'h0) begin
      fails++;
      $display("FAIL reset_state: flags=%b estado=%h addr=%0d jogada=%h required all 0",
               {pronto, acertou, errou, timeout, db_igual}, db_estado, mem_addr, db_jogada);
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h0) begin
      fails++; $display("FAIL idle_inicial: estado=%h required 0", db_estado);
    end
  endtask

  task automatic test_full_match();
    start_game();
    press(4'h1, 1'b1);
    press(4'h2, 1'b1);
    press(4'h4, 1'b1);
    press(4'h8, 1'b1);
    checks++;
    if (pronto !== 1'b0) begin
      fails++; $display("FAIL match_early: pronto=%b required 0", pronto);
    end
    @(negedge clock);
    checks++;
    if (pronto !== 1'b1 || acertou !== 1'b1 || errou !== 1'b0 ||
        db_estado !== 4'hA || mem_addr !== 2'd3) begin
      fails++;
      $display("FAIL match_end: pronto=%b acertou=%b errou=%b estado=%h addr=%0d required 1 1 0 A 3",
               pronto, acertou, errou, db_estado, mem_addr);
    end
  endtask

  task automatic test_mismatch();
    start_game();
    checks++;
    if (pronto !== 1'b0 || acertou !== 1'b0) begin
      fails++; $display("FAIL mismatch_clear: pronto=%b acertou=%b required 0 0", pronto, acertou);
    end
    press(4'h1, 1'b1);
    press(4'h3, 1'b0);
    @(negedge clock);
    checks++;
    if (errou !== 1'b1 || pronto !== 1'b1 || acertou !== 1'b0 ||
        db_estado !== 4'hE || db_contagem !== 2'd1) begin
      fails++;
      $display("FAIL mismatch_end: errou=%b pronto=%b acertou=%b estado=%h cont=%0d required 1 1 0 E 1",
               errou, pronto, acertou, db_estado, db_contagem);
    end
  endtask

  task automatic test_restart();
    start_game();
    @(negedge clock);
    checks++;
    if (pronto !== 1'b0 || errou !== 1'b0 || db_contagem !== 2'd0 || db_estado !== 4'h2) begin
      fails++;
      $display("FAIL restart_clear: pronto=%b errou=%b cont=%0d estado=%h required 0 0 0 2",
               pronto, errou, db_contagem, db_estado);
    end
    press(4'h1, 1'b1);
    press(4'h2, 1'b1);
    press(4'h4, 1'b1);
    press(4'h8, 1'b1);
    @(negedge clock);
    checks++;
    if (acertou !== 1'b1 || pronto !== 1'b1 || db_estado !== 4'hA) begin
      fails++;
      $display("FAIL restart_replay: acertou=%b pronto=%b estado=%h required 1 1 A",
               acertou, pronto, db_estado);
    end
  endtask

  task automatic test_held_switch();
    int n_reg = 0;
    start_game();
    wait_espera();
    chaves = 4'h1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (db_estado === 4'h4) n_reg++;
    end
    checks++;
    if (n_reg !== 1 || db_contagem !== 2'd1 || db_estado !== 4'h3) begin
      fails++;
      $display("FAIL held_switch: registra=%0d cont=%0d estado=%h required 1 1 3",
               n_reg, db_contagem, db_estado);
    end
    chaves = 4'h0;
    @(negedge clock);
    press(4'h2, 1'b1);
  endtask

  task automatic test_reset_midgame();
    wait_espera();
    checks++;
    if (db_contagem !== 2'd2) begin
      fails++; $display("FAIL midgame_index: cont=%0d required 2", db_contagem);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h0 || mem_addr !== 2'd0 || db_jogada !== 4'h0 ||
        {pronto, acertou, errou, timeout, db_igual} !== 5'b0) begin
      fails++;
      $display("FAIL midgame_reset: estado=%h addr=%0d jogada=%h flags=%b required 0 0 0 00000",
               db_estado, mem_addr, db_jogada, {pronto, acertou, errou, timeout, db_igual});
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_timeout();
    start_game();
    repeat (2) @(negedge clock);
`ifdef JOGO_TIMEOUT_EN
    repeat (9) @(negedge clock);
    checks++;
    if (db_estado !== 4'h3 || timeout !== 1'b0) begin
      fails++; $display("FAIL timeout_early: estado=%h timeout=%b required 3 0", db_estado, timeout);
    end
    @(negedge clock);
    checks++;
    if (db_estado !== 4'hD || timeout !== 1'b1 || pronto !== 1'b1 ||
        acertou !== 1'b0 || errou !== 1'b0) begin
      fails++;
      $display("FAIL timeout_end: estado=%h timeout=%b pronto=%b acertou=%b errou=%b required D 1 1 0 0",
               db_estado, timeout, pronto, acertou, errou);
    end
    start_game();
    repeat (2) @(negedge clock);
    repeat (9) @(negedge clock);
    chaves = 4'h1;
    @(negedge clock);
    checks++;
    if (db_estado !== 4'h4 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL timeout_event_priority: estado=%h timeout=%b required 4 0", db_estado, timeout);
    end
    chaves = 4'h0;
`else
    repeat (30) @(negedge clock);
    checks++;
    if (db_estado !== 4'h3 || timeout !== 1'b0 || pronto !== 1'b0) begin
      fails++;
      $display("FAIL no_timeout: estado=%h timeout=%b pronto=%b required 3 0 0",
               db_estado, timeout, pronto);
    end
`endif
  endtask

  initial begin
    mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h4; mem[3] = 4'h8;
    test_reset();
    test_full_match();
    test_mismatch();
    test_restart();
    test_mismatch();
    test_held_switch();
    test_reset_midgame();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/circuito_jogo_sequencia.md
Name: circuito_jogo_sequencia

Overview:
- Parametrised successor of the single-step switch/memory comparison circuit.
- Walks a DEPTH-entry sequence memory and waits for one player move (jogada) per entry, one move at a time.
- Compares each registered move with the memory word and ends in acerto or erro.
- Includes an edge-detected move input, registered memory-read latency handling and an optional inactivity timeout.

Parameters:
- DATA_W, 4, width of moves and memory words.
- DEPTH, 16, number of sequence entries; must be ≥2.
- ADDR_W, $clog2(DEPTH), address/counter width.
- TIMEOUT_CYCLES, 5000, idle cycles allowed in espera; used only with the optional feature.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- iniciar  in  1  start/restart request, level-sampled.
- chaves  in  DATA_W  player move; all-zero means no move.
- mem_data  in  DATA_W  memory read data; valid 1 cycle after mem_addr changes.
- mem_addr  out  ADDR_W  current sequence index.
- pronto  out  1  game finished.
- acertou  out  1  full sequence matched.
- errou  out  1  mismatch detected.
- timeout  out  1  idle timeout ended the game; 0 when the feature is compiled out.
- db_estado  out  4  state encoding.
- db_contagem  out  ADDR_W  counter value.
- db_jogada  out  DATA_W  registered move.
- db_igual  out  1  combinational compare, registered move vs mem_data.

Behaviour:
- Reset: one clock, reset synchronous active-high; on any edge with reset=1, FSM→inicial, counter=0, move register=0, edge-history flop=0; all outputs 0. Reset mid-game aborts with no further outputs.
- States and db_estado encodings: inicial=0, preparacao=1, le_mem=2, espera=3, registra=4, comparacao=5, proximo=6, fim_acerto=A, fim_erro=E, fim_timeout=D.
- inicial: iniciar=1 → preparacao; otherwise stay.
- preparacao: counter and move register cleared; clears pronto/acertou/errou/timeout; → le_mem.
- le_mem: single wait cycle for registered memory read; → espera.
- espera: move event is combinational: jogada_evento = (|chaves) & ~prev, where prev = registered |chaves, updated every cycle in all states.
  - Event → registra.
  - A switch held nonzero on entry generates no event until it returns to 0 and is pressed again.
- registra: move register ← chaves; → comparacao.
- comparacao:
  - db_igual=0 → fim_erro.
  - db_igual=1 and counter==DEPTH-1 → fim_acerto.
  - Otherwise → proximo.
- proximo: counter+1, no wrap possible because the last index exits via fim_acerto; → le_mem.
- Latency: if the event is sampled at edge E, registra runs in E..E+1, comparacao in E+1..E+2, and the fim state (pronto=1) is visible after E+2.
- Fim states:
  - pronto=1 held; acertou=1 in fim_acerto, errou=1 in fim_erro; outputs registered and decoded from state.
  - iniciar=1 → preparacao (restart); move input ignored.
- iniciar is ignored in all states except inicial and the fim states.
- A memory word of 0 can never match, because a zero move cannot be registered; such an entry produces errou on any move.
- Counter and mem_addr are identical; mem_addr is stable from preparacao onward.

Optional Feature:
- Macro: JOGO_TIMEOUT_EN.
- Defined:
  - An idle counter is cleared on entry to espera and increments every cycle in espera.
  - When it reaches TIMEOUT_CYCLES-1 with no event → fim_timeout: pronto=1, timeout=1, acertou=errou=0.
  - An event in the same cycle as the terminal count takes priority, so the FSM goes to registra.
  - In fim_timeout, iniciar restarts the game as in the other fim states.
- Undefined: no idle counter, timeout tied 0, fim_timeout unreachable.

Decomposition:
- Package jogo_pkg:
  - state encodings as 4-bit localparams/enum, so db_estado values are fixed there.
  - Defaults for DATA_W, DEPTH and TIMEOUT_CYCLES.
- One sub-module, edge_detector: 1-bit rising-edge detector with sync reset, instantiated on |chaves.
- FSM, counter and compare stay in the top module.

Test Plan (DATA_W=4, DEPTH=4, memory = 1,2,4,8 with 1-cycle read latency):
- Full match: reset, iniciar pulse; moves 1,2,4,8, each press ≥2 cycles with 0 between presses → acertou=1, pronto=1 two edges after last event, db_estado=A, mem_addr=3.
- Mismatch: moves 1,3 → errou=1, pronto=1, db_estado=E, db_contagem=1; acertou stays 0.
- Held switch: hold chaves=1 for 20 cycles → exactly one registra; counter=1; no second comparison until chaves returns to 0.
- Restart: from fim_erro, iniciar=1 → preparacao; pronto/errou cleared next cycle; counter=0; replaying full sequence → acertou.
- Reset mid-game: reset=1 during espera at index 2 → next edge db_estado=0, all outputs 0, mem_addr=0.
- With JOGO_TIMEOUT_EN and TIMEOUT_CYCLES=10: start, no move for 10 cycles in espera → timeout=1, pronto=1, db_estado=D. Event exactly at count 9 → registra instead.
